// File: rtl/reorder_buffer.sv
// reorder_buffer
//   Circular reorder buffer. Entries are allocated in program order at the
//   tail, completed out of order by tag, and retired in order from the head.
//   Two combinational lookup ports report the youngest in-flight producer of
//   a source register.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   alloc_*                   allocation request / ready / assigned tag
//   fin_valid/tag/data        completion strobe with result
//   commit_*                  head entry handshake and fields
//   lu_rs1/2 -> lu_hit/done/tag/data 1/2   operand lookup ports
//   flush                     synchronous squash of every entry
//   count                     number of occupied entries
module reorder_buffer #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_rd,
  input  logic              alloc_regwrite,
  input  logic              alloc_is_store,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              fin_valid,
  input  logic [TAG_W-1:0]  fin_tag,
  input  logic [DATA_W-1:0] fin_data,
  output logic              commit_valid,
  input  logic              commit_ready,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [REG_W-1:0]  commit_rd,
  output logic              commit_regwrite,
  output logic              commit_is_store,
  output logic [DATA_W-1:0] commit_data,
  input  logic [REG_W-1:0]  lu_rs1,
  input  logic [REG_W-1:0]  lu_rs2,
  output logic              lu_hit1,
  output logic              lu_hit2,
  output logic              lu_done1,
  output logic              lu_done2,
  output logic [TAG_W-1:0]  lu_tag1,
  output logic [TAG_W-1:0]  lu_tag2,
  output logic [DATA_W-1:0] lu_data1,
  output logic [DATA_W-1:0] lu_data2,
  input  logic              flush,
  output logic [TAG_W:0]    count
);

  logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]    count_q, count_d;
  logic [DEPTH-1:0]  valid_q, valid_d, done_q, done_d;
  logic [DEPTH-1:0]  regwrite_q, regwrite_d, is_store_q, is_store_d;
  logic [REG_W-1:0]  rd_q [DEPTH];
  logic [REG_W-1:0]  rd_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  logic alloc_fire, fin_fire, retire_fire;

  // Ready and commit_valid come only from registered state (plus flush), so a
  // retire never frees a slot for an alloc in the same cycle.
  assign alloc_ready  = !flush && (count_q < (TAG_W+1)'(DEPTH));
  assign alloc_tag    = tail_q;
  assign commit_valid = !flush && valid_q[head_q] && done_q[head_q];
  assign commit_tag      = head_q;
  assign commit_rd       = rd_q[head_q];
  assign commit_regwrite = regwrite_q[head_q];
  assign commit_is_store = is_store_q[head_q];
  assign commit_data     = data_q[head_q];
  assign count           = count_q;

  assign alloc_fire  = alloc_valid && alloc_ready;
  // An entry allocated this cycle is not yet valid, so its finish is dropped.
  assign fin_fire    = fin_valid && valid_q[fin_tag] && !done_q[fin_tag];
  assign retire_fire = commit_valid && commit_ready;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    valid_d    = valid_q;
    done_d     = done_q;
    regwrite_d = regwrite_q;
    is_store_d = is_store_q;
    rd_d       = rd_q;
    data_d     = data_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
      done_d  = '0;
    end else begin
      if (fin_fire) begin
        done_d[fin_tag] = 1'b1;
        data_d[fin_tag] = fin_data;
      end
      if (retire_fire) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + TAG_W'(1);
      end
      if (alloc_fire) begin
        valid_d[tail_q]    = 1'b1;
        done_d[tail_q]     = 1'b0;
        rd_d[tail_q]       = alloc_rd;
        regwrite_d[tail_q] = alloc_regwrite;
        is_store_d[tail_q] = alloc_is_store;
        tail_d             = tail_q + TAG_W'(1);
      end
      case ({alloc_fire, retire_fire})
        2'b10:   count_d = count_q + (TAG_W+1)'(1);
        2'b01:   count_d = count_q - (TAG_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      done_q     <= '0;
      regwrite_q <= '0;
      is_store_q <= '0;
      rd_q       <= '{default: '0};
      data_q     <= '{default: '0};
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      regwrite_q <= regwrite_d;
      is_store_q <= is_store_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
    end
  end

  // Walk oldest to youngest starting at head; a later match overwrites an
  // earlier one, so the youngest producer wins.
  logic [TAG_W-1:0] idx;
  always_comb begin
    idx      = '0;
    lu_hit1  = 1'b0;
    lu_done1 = 1'b0;
    lu_tag1  = '0;
    lu_data1 = '0;
    lu_hit2  = 1'b0;
    lu_done2 = 1'b0;
    lu_tag2  = '0;
    lu_data2 = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + TAG_W'(i);
      if (valid_q[idx] && regwrite_q[idx]) begin
        if (lu_rs1 != '0 && rd_q[idx] == lu_rs1) begin
          lu_hit1  = 1'b1;
          lu_done1 = done_q[idx];
          lu_tag1  = idx;
          lu_data1 = done_q[idx] ? data_q[idx] : '0;
        end
        if (lu_rs2 != '0 && rd_q[idx] == lu_rs2) begin
          lu_hit2  = 1'b1;
          lu_done2 = done_q[idx];
          lu_tag2  = idx;
          lu_data2 = done_q[idx] ? data_q[idx] : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int TAG_W  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic alloc_valid, alloc_regwrite, alloc_is_store, alloc_ready;
  logic [REG_W-1:0] alloc_rd;
  logic [TAG_W-1:0] alloc_tag;
  logic fin_valid;
  logic [TAG_W-1:0] fin_tag;
  logic [DATA_W-1:0] fin_data;
  logic commit_valid, commit_ready, commit_regwrite, commit_is_store;
  logic [TAG_W-1:0] commit_tag;
  logic [REG_W-1:0] commit_rd;
  logic [DATA_W-1:0] commit_data;
  logic [REG_W-1:0] lu_rs1, lu_rs2;
  logic lu_hit1, lu_hit2, lu_done1, lu_done2;
  logic [TAG_W-1:0] lu_tag1, lu_tag2;
  logic [DATA_W-1:0] lu_data1, lu_data2;
  logic flush;
  logic [TAG_W:0] count;

  reorder_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_regwrite(alloc_regwrite),
    .alloc_is_store(alloc_is_store), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .fin_valid(fin_valid), .fin_tag(fin_tag), .fin_data(fin_data),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_tag(commit_tag),
    .commit_rd(commit_rd), .commit_regwrite(commit_regwrite),
    .commit_is_store(commit_is_store), .commit_data(commit_data),
    .lu_rs1(lu_rs1), .lu_rs2(lu_rs2), .lu_hit1(lu_hit1), .lu_hit2(lu_hit2),
    .lu_done1(lu_done1), .lu_done2(lu_done2), .lu_tag1(lu_tag1), .lu_tag2(lu_tag2),
    .lu_data1(lu_data1), .lu_data2(lu_data2), .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Program-order list of in-flight instructions; front is the oldest.
  typedef struct {
    int          tag;
    logic [4:0]  rd;
    bit          rw;
    bit          st;
    bit          done;
    logic [31:0] data;
  } ent_t;
  ent_t q[$];
  int   m_tail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    alloc_valid = 0; alloc_rd = '0; alloc_regwrite = 0; alloc_is_store = 0;
    fin_valid = 0; fin_tag = '0; fin_data = '0;
    commit_ready = 0; lu_rs1 = '0; lu_rs2 = '0; flush = 0;
  endtask

  task automatic model_lu(input logic [4:0] rs, output bit hit, output bit dn,
                          output int tg, output logic [31:0] dt);
    hit = 0; dn = 0; tg = 0; dt = '0;
    if (rs != 0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].rw && q[i].rd == rs) begin
          hit = 1; dn = q[i].done; tg = q[i].tag; dt = q[i].data;
          break;
        end
      end
    end
  endtask

  task automatic check_model();
    bit cv, h, d;
    int t;
    logic [31:0] dt;
    chk("count", 64'(count), 64'(q.size()));
    chk("alloc_ready", 64'(alloc_ready), 64'(!flush && q.size() < DEPTH));
    chk("alloc_tag", 64'(alloc_tag), 64'(m_tail));
    cv = !flush && q.size() > 0 && q[0].done;
    chk("commit_valid", 64'(commit_valid), 64'(cv));
    if (cv) begin
      chk("commit_tag", 64'(commit_tag), 64'(q[0].tag));
      chk("commit_rd", 64'(commit_rd), 64'(q[0].rd));
      chk("commit_regwrite", 64'(commit_regwrite), 64'(q[0].rw));
      chk("commit_is_store", 64'(commit_is_store), 64'(q[0].st));
      chk("commit_data", 64'(commit_data), 64'(q[0].data));
    end
    model_lu(lu_rs1, h, d, t, dt);
    chk("lu_hit1", 64'(lu_hit1), 64'(h));
    chk("lu_done1", 64'(lu_done1), 64'(d));
    chk("lu_tag1", 64'(lu_tag1), 64'(t));
    if (!h || d) chk("lu_data1", 64'(lu_data1), 64'(dt));
    model_lu(lu_rs2, h, d, t, dt);
    chk("lu_hit2", 64'(lu_hit2), 64'(h));
    chk("lu_done2", 64'(lu_done2), 64'(d));
    chk("lu_tag2", 64'(lu_tag2), 64'(t));
    if (!h || d) chk("lu_data2", 64'(lu_data2), 64'(dt));
  endtask

  // Advance the model across one clock edge using the pre-edge state.
  task automatic model_edge();
    bit cv, af, rf;
    ent_t e;
    if (flush) begin
      q.delete();
      m_tail = 0;
      return;
    end
    cv = q.size() > 0 && q[0].done;
    rf = cv && commit_ready;
    af = alloc_valid && q.size() < DEPTH;
    if (fin_valid) begin
      foreach (q[i]) begin
        if (q[i].tag == int'(fin_tag) && !q[i].done) begin
          q[i].done = 1;
          q[i].data = fin_data;
        end
      end
    end
    if (rf) void'(q.pop_front());
    if (af) begin
      e.tag = m_tail; e.rd = alloc_rd; e.rw = alloc_regwrite;
      e.st = alloc_is_store; e.done = 0; e.data = '0;
      q.push_back(e);
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  // Called one time unit after a rising edge with inputs already driven.
  task automatic cycle();
    #2;
    check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    #2 rst = 1;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    chk("rst_alloc_tag", 64'(alloc_tag), 64'd0);
    chk("rst_commit_valid", 64'(commit_valid), 64'd0);
    chk("rst_commit_rd", 64'(commit_rd), 64'd0);
    chk("rst_commit_data", 64'(commit_data), 64'd0);
    chk("rst_lu_hit1", 64'(lu_hit1), 64'd0);
    q.delete();
    m_tail = 0;
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic alloc_one(input logic [4:0] rd);
    set_idle();
    alloc_valid = 1; alloc_rd = rd; alloc_regwrite = 1;
    cycle();
  endtask

  task automatic fin_one(input int tag, input logic [31:0] d);
    set_idle();
    fin_valid = 1; fin_tag = TAG_W'(tag); fin_data = d;
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    set_idle();
    @(posedge clk);
    #1;
    do_reset();

    // Fill to capacity, then wrap with retire+alloc.
    for (int i = 0; i < DEPTH; i++) begin
      set_idle();
      alloc_valid = 1; alloc_rd = 5'(i + 1); alloc_regwrite = 1;
      settle();
      chk("fill_tag", 64'(alloc_tag), 64'(i));
      cycle();
    end
    set_idle();
    settle();
    chk("full_count", 64'(count), 64'd8);
    chk("full_ready", 64'(alloc_ready), 64'd0);
    alloc_valid = 1; alloc_rd = 5'd20; alloc_regwrite = 1;
    cycle();
    chk("ninth_count", 64'(count), 64'd8);
    chk("ninth_tail", 64'(alloc_tag), 64'd0);
    fin_one(0, 32'hA0);
    set_idle();
    fin_valid = 1; fin_tag = 3'd1; fin_data = 32'hA1;
    commit_ready = 1; alloc_valid = 1; alloc_rd = 5'd9; alloc_regwrite = 1;
    settle();
    chk("wrap_cv", 64'(commit_valid), 64'd1);
    chk("wrap_ready_full", 64'(alloc_ready), 64'd0);
    cycle();
    chk("wrap_count7", 64'(count), 64'd7);
    set_idle();
    commit_ready = 1; alloc_valid = 1; alloc_rd = 5'd10; alloc_regwrite = 1;
    settle();
    chk("wrap_alloc_tag0", 64'(alloc_tag), 64'd0);
    chk("wrap_commit_tag1", 64'(commit_tag), 64'd1);
    cycle();
    chk("both_count7", 64'(count), 64'd7);

    // Out-of-order completion, in-order retirement.
    do_reset();
    for (int i = 1; i <= 3; i++) alloc_one(5'(i));
    fin_one(2, 32'h33);
    set_idle();
    fin_valid = 1; fin_tag = 3'd0; fin_data = 32'h11;
    settle();
    chk("no_bypass", 64'(commit_valid), 64'd0);
    cycle();
    set_idle();
    settle();
    chk("ooo_cv", 64'(commit_valid), 64'd1);
    chk("ooo_rd", 64'(commit_rd), 64'd1);
    chk("ooo_data", 64'(commit_data), 64'h11);
    commit_ready = 1;
    cycle();
    set_idle();
    commit_ready = 1; fin_valid = 1; fin_tag = 3'd1; fin_data = 32'h22;
    settle();
    chk("ooo_wait", 64'(commit_valid), 64'd0);
    cycle();
    set_idle();
    commit_ready = 1;
    settle();
    chk("ooo_data22", 64'(commit_data), 64'h22);
    cycle();
    settle();
    chk("ooo_cv33", 64'(commit_valid), 64'd1);
    chk("ooo_data33", 64'(commit_data), 64'h33);
    cycle();
    set_idle();
    settle();
    chk("ooo_empty", 64'(count), 64'd0);

    // Lookup picks the youngest producer.
    do_reset();
    alloc_one(5'd5);
    alloc_one(5'd5);
    set_idle();
    lu_rs1 = 5'd5; lu_rs2 = 5'd0;
    settle();
    chk("lu_hit", 64'(lu_hit1), 64'd1);
    chk("lu_tag_young", 64'(lu_tag1), 64'd1);
    chk("lu_notdone", 64'(lu_done1), 64'd0);
    chk("lu_rs0", 64'(lu_hit2), 64'd0);
    fin_valid = 1; fin_tag = 3'd1; fin_data = 32'd7;
    cycle();
    set_idle();
    lu_rs1 = 5'd5;
    settle();
    chk("lu_done", 64'(lu_done1), 64'd1);
    chk("lu_data7", 64'(lu_data1), 64'd7);

    // Flush beats every concurrent event.
    do_reset();
    for (int i = 1; i <= 4; i++) alloc_one(5'(i));
    fin_one(0, 32'h55);
    set_idle();
    settle();
    chk("pre_flush_cv", 64'(commit_valid), 64'd1);
    flush = 1; alloc_valid = 1; alloc_rd = 5'd9; alloc_regwrite = 1;
    commit_ready = 1; fin_valid = 1; fin_tag = 3'd1; fin_data = 32'h66;
    settle();
    chk("flush_ready", 64'(alloc_ready), 64'd0);
    chk("flush_cv", 64'(commit_valid), 64'd0);
    cycle();
    set_idle();
    settle();
    chk("flush_count", 64'(count), 64'd0);
    fin_valid = 1; fin_tag = 3'd1; fin_data = 32'h66; lu_rs1 = 5'd2;
    settle();
    chk("flush_lu", 64'(lu_hit1), 64'd0);
    cycle();
    set_idle();
    settle();
    chk("stale_fin_cv", 64'(commit_valid), 64'd0);
    chk("stale_fin_count", 64'(count), 64'd0);

    // Randomised traffic against the model, with occasional resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 699) do_reset();
      set_idle();
      alloc_valid    = $urandom_range(0, 99) < 55;
      alloc_rd       = 5'($urandom_range(0, 7));
      alloc_regwrite = $urandom_range(0, 3) != 0;
      alloc_is_store = $urandom_range(0, 3) == 0;
      fin_valid      = $urandom_range(0, 99) < 60;
      if (q.size() > 0 && $urandom_range(0, 99) < 80)
        fin_tag = TAG_W'(q[$urandom_range(0, q.size() - 1)].tag);
      else
        fin_tag = TAG_W'($urandom_range(0, DEPTH - 1));
      fin_data     = $urandom;
      commit_ready = $urandom_range(0, 99) < 70;
      flush        = $urandom_range(0, 99) == 0;
      lu_rs1       = 5'($urandom_range(0, 7));
      lu_rs2       = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
